fetch_unit: RTL

//  Instruction-fetch stage of the single-cycle/pipelined MIPS core; sits directly upstream of im_4k.

---
 rtl/fetch_unit_if.sv | 51 +++++
 rtl/fetch_unit.sv | 112 +++++++++++
 2 files changed

// File: rtl/fetch_unit_if.sv
// Fetch-stage bus: instruction-memory port, fetch->decode handshake and decode's redirect request.
// master = fetch_unit side, slave = memory/decode side.
interface fetch_unit_if #(
    parameter int IM_AW = 12
);
    // Handshake: if_valid/if_inst/if_pc are driven by fetch and held stable while
    // if_valid & ~id_ready; an instruction transfers on a rising edge where
    // if_valid & id_ready, and npc_sel/imm16/imm26/jr_target are sampled only then.
    logic [IM_AW-1:0] im_addr;
    logic [31:0]      im_dout;
    logic             if_valid;
    logic             id_ready;
    logic [31:0]      if_inst;
    logic [31:0]      if_pc;
    logic [1:0]       npc_sel;
    logic [15:0]      imm16;
    logic [25:0]      imm26;
    logic [31:0]      jr_target;
    logic             exc;
    logic [31:0]      exc_pc;

    modport master (
        output im_addr,
        input  im_dout,
        output if_valid,
        input  id_ready,
        output if_inst,
        output if_pc,
        input  npc_sel,
        input  imm16,
        input  imm26,
        input  jr_target,
        output exc,
        output exc_pc
    );

    modport slave (
        input  im_addr,
        output im_dout,
        input  if_valid,
        output id_ready,
        input  if_inst,
        input  if_pc,
        output npc_sel,
        output imm16,
        output imm26,
        output jr_target,
        input  exc,
        input  exc_pc
    );
endinterface

// File: rtl/fetch_unit.sv
// MIPS instruction-fetch stage: PC, imem addressing, capture register and next-PC selection.
// Optional macro FETCH_TRACE_EN adds a simulation-only trace of captured words and fault entry.
module fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_3000,
    parameter int          IM_AW    = 12
) (
    input  logic          clk,
    input  logic          rst,
    fetch_unit_if.master  bus,
    output logic [1:0]    dbg_state
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        FAULT = 2'd2
    } state_t;

    state_t      state;
    logic [31:0] pc_q;
    logic        valid_q;
    logic [31:0] inst_q;
    logic [31:0] ipc_q;
    logic        exc_q;
    logic [31:0] exc_pc_q;

    logic        accept;
    logic        load;
    logic        redirect;
    logic        jr_bad;
    logic [31:0] if_pc_plus4;
    logic [31:0] br_off;
    logic [31:0] target;

    assign bus.im_addr  = pc_q[IM_AW+1:2];
    assign bus.if_valid = valid_q;
    assign bus.if_inst  = inst_q;
    assign bus.if_pc    = ipc_q;
    assign bus.exc      = exc_q;
    assign bus.exc_pc   = exc_pc_q;
    assign dbg_state    = state;

    always_comb begin
        accept      = valid_q & bus.id_ready;
        load        = (state == RUN) & (~valid_q | bus.id_ready);
        redirect    = (state == RUN) & accept & (bus.npc_sel != 2'b00);
        if_pc_plus4 = ipc_q + 32'd4;
        br_off      = {{14{bus.imm16[15]}}, bus.imm16, 2'b00};
        target      = pc_q + 32'd4;
        unique case (bus.npc_sel)
            2'b01:   target = if_pc_plus4 + br_off;
            2'b10:   target = {if_pc_plus4[31:28], bus.imm26, 2'b00};
            2'b11:   target = bus.jr_target;
            default: target = pc_q + 32'd4;
        endcase
        jr_bad = (bus.npc_sel == 2'b11) & (bus.jr_target[1:0] != 2'b00);
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state    <= IDLE;
            pc_q     <= RESET_PC;
            valid_q  <= 1'b0;
            inst_q   <= 32'd0;
            ipc_q    <= 32'd0;
            exc_q    <= 1'b0;
            exc_pc_q <= 32'd0;
        end else begin
            unique case (state)
                IDLE: begin
                    state <= RUN;
                end
                RUN: begin
                    // Redirect beats load: the word on im_dout this cycle is wrong-path.
                    if (redirect) begin
                        valid_q <= 1'b0;
                        if (jr_bad) begin
                            state    <= FAULT;
                            exc_q    <= 1'b1;
                            exc_pc_q <= ipc_q;
                        end else begin
                            pc_q <= target;
                        end
                    end else if (load) begin
                        inst_q  <= bus.im_dout;
                        ipc_q   <= pc_q;
                        valid_q <= 1'b1;
                        pc_q    <= pc_q + 32'd4;
                    end
                end
                FAULT: begin
                    valid_q <= 1'b0;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

`ifdef FETCH_TRACE_EN
    always_ff @(posedge clk) begin
        if (rst && load && !redirect)
            $display("fetch pc=%08X inst=%08X", pc_q, bus.im_dout);
        if (rst && redirect && jr_bad)
            $display("fetch fault pc=%08X tgt=%08X", ipc_q, bus.jr_target);
    end
`else
    // Trace disabled: no simulation output.
`endif

endmodule
